// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, FSM state enum and access-size helper
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD0  = 3'd1,
      S_RD1  = 3'd2,
      S_WR0  = 3'd3,
      S_WR1  = 3'd4,
      S_RESP = 3'd5
   } lsu_state_t;

   // Access size in bytes; illegal codes fall to 4 and are filtered by the legality check
   function automatic logic [2:0] size_of(input logic [2:0] funct3);
      case (funct3)
         F3_B, F3_BU: return 3'd1;
         F3_H, F3_HU: return 3'd2;
         default:     return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores and load extraction/extension
import lsu_pkg::*;

module lsu_align (
   input  logic [1:0]  off,
   input  logic [2:0]  size,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   input  logic [31:0] word0,
   input  logic [31:0] word1,
   output logic [7:0]  lane_mask,
   output logic [63:0] wdata_sh,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   // Store lanes across the two-word window, and the load window shifted down to byte 0
   always_comb begin
      lane_mask = ((8'd1 << size) - 8'd1) << off;
      wdata_sh  = {32'd0, wdata} << {off, 3'b000};
      shifted   = 32'({word1, word0} >> {off, 3'b000});
   end

   // Truncate to the access size, then sign- or zero-extend
   always_comb begin
      case (funct3)
         F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   load_data = {24'd0, shifted[7:0]};
         F3_HU:   load_data = {16'd0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-addressed load/store sequencer over a word-wide memory port
import lsu_pkg::*;

module load_store_unit #(
   parameter int MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

   lsu_state_t  state, state_nxt;
   logic        l_store, l_err;
   logic [2:0]  l_f3;
   logic [31:0] l_addr, l_wdata, old0, old1;

   logic [2:0]  rq_size, l_size;
   logic [29:0] rq_w0, rq_w1, l_w0, l_w1;
   logic        rq_cross, rq_legal, rq_err, l_cross;
   logic [7:0]  lane_mask;
   logic [63:0] wdata_sh;
   logic [31:0] load_data, merge0, merge1;

   // Decode the incoming request: legality, word-crossing and range
   always_comb begin
      rq_size  = size_of(req_funct3);
      rq_w0    = req_addr[31:2];
      rq_w1    = rq_w0 + 30'd1;
      rq_cross = ({1'b0, req_addr[1:0]} + rq_size) > 3'd4;
      if (req_store)
         rq_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
      else
         rq_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                    (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
      rq_err   = !rq_legal || (rq_w0 >= WORD_LIMIT) || (rq_cross && (rq_w1 >= WORD_LIMIT));
   end

   // Same geometry recomputed from the latched request
   always_comb begin
      l_size  = size_of(l_f3);
      l_w0    = l_addr[31:2];
      l_w1    = l_w0 + 30'd1;
      l_cross = ({1'b0, l_addr[1:0]} + l_size) > 3'd4;
   end

   lsu_align u_align (
      .off       (l_addr[1:0]),
      .size      (l_size),
      .funct3    (l_f3),
      .wdata     (l_wdata),
      .word0     (old0),
      .word1     (old1),
      .lane_mask (lane_mask),
      .wdata_sh  (wdata_sh),
      .load_data (load_data)
   );

   // Replace only the masked lanes of each old word; an aligned SW masks all four lanes
   always_comb begin
      merge0 = old0;
      merge1 = old1;
      for (int i = 0; i < 4; i++) begin
         if (lane_mask[i])     merge0[8*i +: 8] = wdata_sh[8*i +: 8];
         if (lane_mask[4 + i]) merge1[8*i +: 8] = wdata_sh[32 + 8*i +: 8];
      end
   end

   // State register plus request latch and read-data capture
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         l_store <= 1'b0;
         l_err   <= 1'b0;
         l_f3    <= 3'd0;
         l_addr  <= 32'd0;
         l_wdata <= 32'd0;
         old0    <= 32'd0;
         old1    <= 32'd0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && req_valid) begin
            l_store <= req_store;
            l_err   <= rq_err;
            l_f3    <= req_funct3;
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
         end
         if (state == S_RD0) old0 <= mem_rdata;
         if (state == S_RD1) old1 <= mem_rdata;
      end
   end

   // Next-state sequencing for loads, read-modify-write stores and errors
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               if (rq_err)
                  state_nxt = S_RESP;
               else if (req_store && req_funct3 == F3_W && req_addr[1:0] == 2'b00)
                  state_nxt = S_WR0;
               else
                  state_nxt = S_RD0;
            end
         end
         S_RD0:   state_nxt = l_store ? S_WR0 : (l_cross ? S_RD1 : S_RESP);
         S_RD1:   state_nxt = l_store ? S_WR1 : S_RESP;
         S_WR0:   state_nxt = (l_store && l_cross) ? S_RD1 : S_RESP;
         S_WR1:   state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Memory drive and response outputs; strobes are suppressed while reset is high
   always_comb begin
      req_ready  = (state == S_IDLE);
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = 32'd0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = 32'd0;
      mem_wdata  = 32'd0;
      case (state)
         S_RD0: begin
            mem_rd   = !reset;
            mem_addr = {2'b00, l_w0};
         end
         S_RD1: begin
            mem_rd   = !reset;
            mem_addr = {2'b00, l_w1};
         end
         S_WR0: begin
            mem_wr    = !reset;
            mem_addr  = {2'b00, l_w0};
            mem_wdata = merge0;
         end
         S_WR1: begin
            mem_wr    = !reset;
            mem_addr  = {2'b00, l_w1};
            mem_wdata = merge1;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_err   = l_err;
            resp_rdata = (l_err || l_store) ? 32'd0 : load_data;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a behavioural memory
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_store = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_rd, mem_wr;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [0:63];
   logic        bd_we = 1'b0;
   logic [5:0]  bd_addr = 6'd0;
   logic [31:0] bd_data = 32'd0;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] ops[$];
   bit         both_seen = 1'b0;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_WORDS(64)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   assign mem_rdata = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'd0;

   always @(posedge clk) begin
      if (mem_wr && mem_addr < 32'd64) mem[mem_addr[5:0]] <= mem_wdata;
      else if (bd_we)                  mem[bd_addr] <= bd_data;
   end

   always @(negedge clk) begin
      if (mem_rd) ops.push_back({2'b01, mem_addr[5:0]});
      if (mem_wr) ops.push_back({2'b10, mem_addr[5:0]});
      if (mem_rd && mem_wr) both_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic poke(input int a, input logic [31:0] d);
      bd_addr = 6'(a);
      bd_data = d;
      bd_we   = 1'b1;
      @(posedge clk);
      #1 bd_we = 1'b0;
   endtask

   // Reference load built byte by byte from the memory model
   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
      int          n;
      logic [31:0] v, w;
      logic [7:0]  bt;
      n  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      v  = 32'd0;
      bt = 8'd0;
      for (int i = 0; i < n; i++) begin
         w  = mem[6'((a + 32'(i)) >> 2)];
         bt = w[8*((a + 32'(i)) % 4) +: 8];
         v[8*i +: 8] = bt;
      end
      if (!f3[2] && n < 4 && bt[7]) begin
         for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      end
      return v;
   endfunction

   task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                         input int e_lat, input string tag);
      exp_t e;
      int   cnt, guard;
      bit   got;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      ops.delete();
      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      sb.push_back('{err: e_err, rdata: e_rd, lat: e_lat});
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      cnt = 1;
      got = 1'b0;
      while (cnt < 20) begin
         @(negedge clk);
         if (resp_valid) begin
            got = 1'b1;
            break;
         end
         cnt++;
      end
      check({tag, "_resp_seen"}, 64'(got), 64'd1);
      if (got) begin
         e = sb.pop_front();
         check({tag, "_lat"}, 64'(cnt), 64'(e.lat));
         check({tag, "_err"}, 64'(resp_err), 64'(e.err));
         check({tag, "_rdata"}, 64'(resp_rdata), 64'(e.rdata));
      end else begin
         sb.delete();
      end
      @(negedge clk);
      check({tag, "_pulse_end"}, 64'(resp_valid), 64'd0);
      check({tag, "_ready_back"}, 64'(req_ready), 64'd1);
   endtask

   initial begin
      int          seen, n;
      bit          rv;
      logic [31:0] a, ex;
      logic [2:0]  f3;
      logic [2:0]  f3_tab [5];
      f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

      for (int i = 0; i < 64; i++) poke(i, $urandom);
      poke(0, 32'h8877_6655);
      poke(1, 32'h4433_2211);
      poke(2, 32'hDDCC_BBAA);
      poke(3, 32'hFFFF_FFFF);
      poke(4, 32'h1122_3344);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready", 64'(req_ready), 64'd1);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_err", 64'(resp_err), 64'd0);
      check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
      check("rst_mem_strobes", 64'({mem_rd, mem_wr}), 64'd0);

      do_req(1'b0, 3'b000, 32'h3, 32'd0, 1'b0, 32'hFFFF_FF88, 2, "lb3");
      do_req(1'b0, 3'b100, 32'h3, 32'd0, 1'b0, 32'h0000_0088, 2, "lbu3");
      do_req(1'b0, 3'b001, 32'h0, 32'd0, 1'b0, 32'h0000_6655, 2, "lh0");
      do_req(1'b0, 3'b010, 32'h6, 32'd0, 1'b0, 32'hBBAA_4433, 3, "lw6");
      check("lw6_nops", 64'(ops.size()), 64'd2);
      if (ops.size() == 2) begin
         check("lw6_op0", 64'(ops[0]), 64'h41);
         check("lw6_op1", 64'(ops[1]), 64'h42);
      end

      do_req(1'b1, 3'b000, 32'hD, 32'h0000_0012, 1'b0, 32'd0, 3, "sbD");
      check("sbD_word3", 64'(mem[3]), 64'hFFFF_12FF);

      poke(3, 32'hFFFF_FFFF);
      do_req(1'b1, 3'b001, 32'hF, 32'h0000_ABCD, 1'b0, 32'd0, 5, "shF");
      check("shF_word3", 64'(mem[3]), 64'hCDFF_FFFF);
      check("shF_word4", 64'(mem[4]), 64'h1122_33AB);
      check("shF_nops", 64'(ops.size()), 64'd4);
      if (ops.size() == 4) begin
         check("shF_op0", 64'(ops[0]), 64'h43);
         check("shF_op1", 64'(ops[1]), 64'h83);
         check("shF_op2", 64'(ops[2]), 64'h44);
         check("shF_op3", 64'(ops[3]), 64'h84);
      end

      do_req(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 1'b0, 32'd0, 2, "sw8");
      check("sw8_word2", 64'(mem[2]), 64'hDEAD_BEEF);
      check("sw8_nops", 64'(ops.size()), 64'd1);
      if (ops.size() == 1) check("sw8_op0", 64'(ops[0]), 64'h82);

      do_req(1'b0, 3'b011, 32'h0, 32'd0, 1'b1, 32'd0, 1, "err_f3");
      check("err_f3_nops", 64'(ops.size()), 64'd0);
      do_req(1'b0, 3'b010, 32'h100, 32'd0, 1'b1, 32'd0, 1, "err_w64");
      check("err_w64_nops", 64'(ops.size()), 64'd0);
      do_req(1'b0, 3'b001, 32'hFF, 32'd0, 1'b1, 32'd0, 1, "err_cross");
      check("err_cross_nops", 64'(ops.size()), 64'd0);
      do_req(1'b1, 3'b100, 32'h4, 32'h55, 1'b1, 32'd0, 1, "err_st_f3");
      check("err_st_f3_nops", 64'(ops.size()), 64'd0);
      do_req(1'b0, 3'b010, 32'hFC, 32'd0, 1'b0, mem[63], 2, "lw_last");

      for (int i = 0; i < 10; i++) begin
         a  = {$urandom_range(0, 8), 2'(i)} & 32'h3F;
         f3 = f3_tab[$urandom_range(0, 4)];
         n  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
         ex = ref_load(a, f3);
         do_req(1'b0, f3, a, 32'd0, 1'b0, ex, ((int'(a[1:0]) + n) > 4) ? 3 : 2, "rnd_ld");
      end

      poke(3, 32'hFFFF_FFFF);
      poke(4, 32'h1122_3344);
      @(negedge clk);
      req_valid  = 1'b1;
      req_store  = 1'b1;
      req_funct3 = 3'b001;
      req_addr   = 32'hF;
      req_wdata  = 32'h0000_ABCD;
      @(posedge clk);
      #1 req_valid = 1'b0;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (mem_wr) begin
            seen = 1;
            break;
         end
      end
      check("rstmid_wr0_seen", 64'(seen), 64'd1);
      reset = 1'b1;
      #1;
      check("rstmid_mem_wr", 64'(mem_wr), 64'd0);
      check("rstmid_mem_rd", 64'(mem_rd), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rstmid_ready", 64'(req_ready), 64'd1);
      rv = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (resp_valid) rv = 1'b1;
      end
      check("rstmid_no_resp", 64'(rv), 64'd0);
      check("rstmid_word3", 64'(mem[3]), 64'hFFFF_FFFF);
      check("rstmid_word4", 64'(mem[4]), 64'h1122_3344);

      check("rd_wr_exclusive", 64'(both_seen), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
